// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter4
// Purpose  : Four-requester round-robin arbiter with registered one-hot grant,
//            encoded index and a one-cycle dead gap between grants.
//            Optional forced release after HOLD_MAX cycles: ARB_HOLD_TIMEOUT_EN
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter4 #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    if ((HOLD_MAX < 2) || (HOLD_MAX > 15) || ((2 ** CNT_W) <= HOLD_MAX)) begin : g_param_check
        $error("rr_arbiter4: HOLD_MAX must be 2..15 and fit in CNT_W bits");
    end

    state_t     r_state;
    logic [1:0] r_ptr;
    logic [3:0] r_gnt;
    logic [1:0] r_gnt_idx;

    logic [3:0] w_rot;
    logic [1:0] w_off;
    logic       w_any;
    logic [1:0] w_pick;
    logic [3:0] w_pick_onehot;
    logic       w_hold;
    logic       w_force;

    // Rotate req so that bit 0 is the requester currently at the head of the order.
    always_comb begin
        w_rot = req;
        case (r_ptr)
            2'd0:    w_rot = req;
            2'd1:    w_rot = {req[0],   req[3:1]};
            2'd2:    w_rot = {req[1:0], req[3:2]};
            default: w_rot = {req[2:0], req[3]};
        endcase
    end

    always_comb begin
        w_off = 2'd3;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
        else               w_off = 2'd3;
    end

    assign w_any         = |req;
    assign w_pick        = r_ptr + w_off;
    assign w_pick_onehot = 4'b0001 << w_pick;
    assign w_hold        = req[r_gnt_idx];

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_hold_max  = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    // Only a still-held grant with someone else waiting is cut short.
    assign w_force = w_hold && (r_cnt == c_hold_last) && |(req & ~r_gnt);
    assign timeout = r_timeout;
`else
    assign w_force = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 2'd0;
            r_gnt     <= 4'b0000;
            r_gnt_idx <= 2'd0;
`ifdef ARB_HOLD_TIMEOUT_EN
            r_cnt     <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef ARB_HOLD_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                ST_IDLE, ST_GAP: begin
                    if (w_any) begin
                        r_state   <= ST_GRANT;
                        r_gnt     <= w_pick_onehot;
                        r_gnt_idx <= w_pick;
`ifdef ARB_HOLD_TIMEOUT_EN
                        r_cnt     <= '0;
`endif
                    end else begin
                        r_state   <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (!w_hold || w_force) begin
                        r_state <= ST_GAP;
                        r_gnt   <= 4'b0000;
                        r_ptr   <= r_gnt_idx + 2'd1;
`ifdef ARB_HOLD_TIMEOUT_EN
                        r_timeout <= w_force;
                    end else if (r_cnt != c_hold_max) begin
                        r_cnt <= r_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 4'b0000;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = |r_gnt;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter4
// Purpose  : Directed table-driven bench for rr_arbiter4 (HOLD_MAX=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;

    rr_arbiter4 #(.HOLD_MAX(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
        logic       tmo;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] g,
                       input logic [1:0] i, input logic v, input logic t);
        vec_t e;
        e.rst_n = r; e.req = rq; e.gnt = g; e.idx = i; e.valid = v; e.tmo = t;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input logic [3:0] g, input logic [1:0] i,
                         input logic v, input logic t);
        n_cmp++;
        if (gnt !== g || gnt_idx !== i || gnt_valid !== v || timeout !== t ||
            $countones(gnt) > 1) begin
            n_err++;
            $display("FAIL %s: got gnt=%b idx=%b valid=%b timeout=%b, want gnt=%b idx=%b valid=%b timeout=%b",
                     name, gnt, gnt_idx, gnt_valid, timeout, g, i, v, t);
        end
    endtask

    // Drive inputs just after an edge, then sample 1 time unit after the next edge.
    task automatic apply(input logic r, input logic [3:0] rq);
        rst_n = r;
        req   = rq;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // idle after reset
        for (int k = 0; k < 5; k++) add(1, 4'b0000, 4'b0000, 2'd0, 0, 0);
        // single requester 2, held three cycles then dropped
        add(1, 4'b0100, 4'b0100, 2'd2, 1, 0);
        add(1, 4'b0100, 4'b0100, 2'd2, 1, 0);
        add(1, 4'b0100, 4'b0100, 2'd2, 1, 0);
        add(1, 4'b0000, 4'b0000, 2'd2, 0, 0);
        add(1, 4'b0000, 4'b0000, 2'd2, 0, 0);
        // reset so the pointer is back at 0, then full rotation
        add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
        add(1, 4'b1111, 4'b0001, 2'd0, 1, 0);
        add(1, 4'b1111, 4'b0001, 2'd0, 1, 0);
        add(1, 4'b1110, 4'b0000, 2'd0, 0, 0);
        add(1, 4'b1111, 4'b0010, 2'd1, 1, 0);
        add(1, 4'b1111, 4'b0010, 2'd1, 1, 0);
        add(1, 4'b1101, 4'b0000, 2'd1, 0, 0);
        add(1, 4'b1111, 4'b0100, 2'd2, 1, 0);
        add(1, 4'b1111, 4'b0100, 2'd2, 1, 0);
        add(1, 4'b1011, 4'b0000, 2'd2, 0, 0);
        add(1, 4'b1111, 4'b1000, 2'd3, 1, 0);
        add(1, 4'b1111, 4'b1000, 2'd3, 1, 0);
        add(1, 4'b0111, 4'b0000, 2'd3, 0, 0);
        add(1, 4'b1111, 4'b0001, 2'd0, 1, 0);
        // grant 3, wrap pointer to 0, then 1010 in the gap picks requester 1
        add(1, 4'b1000, 4'b0000, 2'd0, 0, 0);
        add(1, 4'b1000, 4'b1000, 2'd3, 1, 0);
        add(1, 4'b0000, 4'b0000, 2'd3, 0, 0);
        add(1, 4'b1010, 4'b0010, 2'd1, 1, 0);
        add(1, 4'b1010, 4'b0010, 2'd1, 1, 0);
        add(1, 4'b1111, 4'b0010, 2'd1, 1, 0);
        add(1, 4'b0000, 4'b0000, 2'd1, 0, 0);
        add(1, 4'b0000, 4'b0000, 2'd1, 0, 0);

        // asynchronous reset, checked before any clock edge
        #1 rst_n = 1'b0;
        #1 check("reset_async", 4'b0000, 2'd0, 0, 0);
        @(posedge clk); #1;

        for (int k = 0; k < vecs.size(); k++) begin
            apply(vecs[k].rst_n, vecs[k].req);
            check($sformatf("vec%0d", k), vecs[k].gnt, vecs[k].idx, vecs[k].valid, vecs[k].tmo);
        end

        // hold limit: req[0] held, req[2] joins one cycle later
        apply(0, 4'b0000);
        check("hold_reset", 4'b0000, 2'd0, 0, 0);
        apply(1, 4'b0001);
        check("hold_c0", 4'b0001, 2'd0, 1, 0);
        for (int k = 1; k < 4; k++) begin
            apply(1, 4'b0101);
            check($sformatf("hold_c%0d", k), 4'b0001, 2'd0, 1, 0);
        end
`ifdef ARB_HOLD_TIMEOUT_EN
        apply(1, 4'b0101);
        check("hold_forced", 4'b0000, 2'd0, 0, 1);
        apply(1, 4'b0101);
        check("hold_next", 4'b0100, 2'd2, 1, 0);
`else
        for (int k = 4; k < 10; k++) begin
            apply(1, 4'b0101);
            check($sformatf("hold_c%0d", k), 4'b0001, 2'd0, 1, 0);
        end
`endif

        // asynchronous reset in the middle of a grant to requester 3
        apply(0, 4'b0000);
        check("mid_reset_pre", 4'b0000, 2'd0, 0, 0);
        apply(1, 4'b1000);
        check("mid_grant3", 4'b1000, 2'd3, 1, 0);
        #1 rst_n = 1'b0;
        #1 check("mid_reset_async", 4'b0000, 2'd0, 0, 0);
        #1 rst_n = 1'b1;
        req = 4'b1111;
        @(posedge clk); #1;
        check("post_reset_first", 4'b0001, 2'd0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
